// File: rtl/pe_pkg.sv
// Shared types and constants for the PE multiply-accumulate sequencer.
package pe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_RD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam int unsigned CLR_CYCLES = 2;
  localparam int unsigned DATA_W     = 32;

  localparam logic [DATA_W-1:0] ONE = 32'h3F80_0000;
  localparam logic [DATA_W-1:0] TWO = 32'h4000_0000;

endpackage

// File: rtl/pe_ctrl_timeout.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module pe_ctrl_timeout #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == '0);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/pe_mac_ctrl.sv
// Sequencer for one PE: loads the B-vector, clears the accumulator, then
// streams an A-row through the multiply-add core one element at a time.
module pe_mac_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned L_RAM_SIZE = 6,
  parameter int unsigned DV_TIMEOUT = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  cmd_load,
  input  logic [L_RAM_SIZE:0]   cmd_len,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [31:0]           b_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [31:0]           a_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic                  busy,
  output logic                  err,
  output logic                  pe_aresetn,
  output logic                  pe_we,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic [31:0]           pe_din,
  output logic [31:0]           pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [31:0]           pe_dout
);

  localparam int unsigned LEN_W   = L_RAM_SIZE + 1;
  localparam int unsigned VEC_MAX = 1 << L_RAM_SIZE;
  localparam int unsigned TMO_W   = $clog2(DV_TIMEOUT + 1);
  localparam int unsigned CLR_W   = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [CLR_W-1:0]      clr_q, clr_d;
  logic                  err_q, err_d;
  logic [31:0]           res_data_q, res_data_d;
  logic                  busy_q, busy_d;
  logic                  a_ready_q, a_ready_d;
  logic                  b_ready_q, b_ready_d;
  logic                  res_valid_q, res_valid_d;
  logic                  pe_valid_q, pe_valid_d;
  logic                  clear_q, clear_d;
  logic                  pe_we_q, pe_we_d;
  logic [L_RAM_SIZE-1:0] pe_addr_q, pe_addr_d;
  logic [31:0]           pe_din_q, pe_din_d;
  logic [31:0]           pe_ain_q, pe_ain_d;
  logic [LEN_W-1:0]      len_clamp_c;
  logic                  tmo_expired;

  assign len_clamp_c = (cmd_len > LEN_W'(VEC_MAX)) ? LEN_W'(VEC_MAX) : cmd_len;

  pe_ctrl_timeout #(
    .CNT_W (TMO_W)
  ) u_timeout (
    .clk_i      (aclk),
    .rstn_i     (aresetn),
    .load_i     (state_q == S_ISSUE),
    .load_val_i (TMO_W'(DV_TIMEOUT - 1)),
    .en_i       (state_q == S_WAIT),
    .expired_o  (tmo_expired)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    clr_d      = clr_q;
    err_d      = err_q;
    res_data_d = res_data_q;
    pe_we_d    = 1'b0;
    pe_addr_d  = pe_addr_q;
    pe_din_d   = pe_din_q;
    pe_ain_d   = pe_ain_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = len_clamp_c;
          cnt_d      = '0;
          idx_d      = '0;
          clr_d      = '0;
          err_d      = 1'b0;
          res_data_d = '0;
          state_d    = (cmd_load && (len_clamp_c != '0)) ? S_LOAD : S_CLR;
        end
      end
      S_LOAD: begin
        if (b_valid && b_ready_q) begin
          pe_we_d   = 1'b1;
          pe_din_d  = b_data;
          pe_addr_d = cnt_q[L_RAM_SIZE-1:0];
          cnt_d     = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (clr_q == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = (len_q == '0) ? S_DONE : S_RD;
        end else begin
          clr_d = clr_q + CLR_W'(1);
        end
      end
      S_RD: begin
        if (a_valid && a_ready_q) begin
          pe_ain_d = a_data;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A result beats a simultaneous timeout
        if (pe_dvalid) begin
          res_data_d = pe_dout;
          idx_d      = idx_q + LEN_W'(1);
          state_d    = (idx_d == len_q) ? S_DONE : S_RD;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready && res_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RD) pe_addr_d = idx_d[L_RAM_SIZE-1:0];

    busy_d      = (state_d != S_IDLE);
    a_ready_d   = (state_d == S_RD);
    b_ready_d   = (state_d == S_LOAD);
    res_valid_d = (state_d == S_DONE);
    pe_valid_d  = (state_d == S_ISSUE);
    clear_d     = (state_d == S_CLR);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      clr_q       <= '0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      pe_valid_q  <= 1'b0;
      clear_q     <= 1'b0;
      pe_we_q     <= 1'b0;
      pe_addr_q   <= '0;
      pe_din_q    <= '0;
      pe_ain_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      clr_q       <= clr_d;
      err_q       <= err_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      a_ready_q   <= a_ready_d;
      b_ready_q   <= b_ready_d;
      res_valid_q <= res_valid_d;
      pe_valid_q  <= pe_valid_d;
      clear_q     <= clear_d;
      pe_we_q     <= pe_we_d;
      pe_addr_q   <= pe_addr_d;
      pe_din_q    <= pe_din_d;
      pe_ain_q    <= pe_ain_d;
    end
  end

  // PE reset follows the system reset directly, plus the CLR pulse
  assign pe_aresetn = aresetn & ~clear_q;

  assign busy      = busy_q;
  assign err       = err_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign a_ready   = a_ready_q;
  assign b_ready   = b_ready_q;
  assign pe_valid  = pe_valid_q;
  assign pe_we     = pe_we_q;
  assign pe_addr   = pe_addr_q;
  assign pe_din    = pe_din_q;
  assign pe_ain    = pe_ain_q;

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Directed bench for pe_mac_ctrl with a behavioural PE (RAM + multiply-add
// core with fixed latency and a feedback accumulator).
module tb_pe_mac_ctrl;
  import pe_pkg::*;

  localparam int unsigned LRS = 6;
  localparam int unsigned DVT = 16;
  localparam int unsigned LFP = 5;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          cmd_load = 1'b0;
  logic [LRS:0]  cmd_len = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [31:0]   b_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [31:0]   a_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_data;
  logic          busy;
  logic          err;
  logic          pe_aresetn;
  logic          pe_we;
  logic [LRS-1:0] pe_addr;
  logic [31:0]   pe_din;
  logic [31:0]   pe_ain;
  logic          pe_valid;
  logic          pe_dvalid;
  logic [31:0]   pe_dout;

  pe_mac_ctrl #(.L_RAM_SIZE(LRS), .DV_TIMEOUT(DVT)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .cmd_load(cmd_load),
    .cmd_len(cmd_len), .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err), .pe_aresetn(pe_aresetn), .pe_we(pe_we),
    .pe_addr(pe_addr), .pe_din(pe_din), .pe_ain(pe_ain), .pe_valid(pe_valid),
    .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Exact float<->int conversion for the small positive integers used here
  function automatic int f2i(input logic [31:0] x);
    int e;
    logic [23:0] m;
    if (x[30:0] == 31'd0) return 0;
    e = int'(x[30:23]) - 127;
    m = {1'b1, x[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 31; i++) if (v[i]) p = i;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(p + 127), m[22:0]};
  endfunction

  logic [31:0]    ram [64];
  logic [31:0]    ram_rd;
  logic [LFP-1:0] sr = '0;
  int             acc = 0;
  int             pend = 0;
  bit             suppress = 1'b0;

  always @(posedge aclk) begin
    if (pe_we) ram[pe_addr] <= pe_din;
    ram_rd <= ram[pe_addr];
    if (!pe_aresetn) begin
      sr   <= '0;
      acc  <= 0;
      pend <= 0;
    end else begin
      sr <= {sr[LFP-2:0], pe_valid};
      if (pe_valid) pend <= acc + f2i(ram_rd) * f2i(pe_ain);
      if (pe_dvalid) acc <= pend;
    end
  end

  assign pe_dvalid = sr[LFP-1] & ~suppress;
  assign pe_dout   = i2f(pend);

  int          r_start, r_issues, r_first_issue, r_last_issue, r_min_gap;
  int          r_last_dv, r_resv, r_stall_rd;
  bit          r_overlap, r_ab_ready, r_done, r_stall_pv, r_err;
  logic [31:0] r_data;

  task automatic run_cmd(input logic load, input logic [LRS:0] len,
                         input logic [31:0] bw, input logic [31:0] aw,
                         input int stall_after, input int stall_cycles);
    int a_cnt = 0;
    int b_cnt = 0;
    int n = int'(len);
    int stall_left = stall_cycles;
    bit outstanding = 1'b0;
    bit seen_rd = 1'b0;
    r_issues = 0; r_first_issue = -1; r_last_issue = -1; r_min_gap = 1000;
    r_last_dv = -1; r_resv = -1; r_stall_rd = 0; r_overlap = 0;
    r_ab_ready = 0; r_done = 0; r_stall_pv = 0; r_err = 0; r_data = 'x;
    @(negedge aclk);
    start = 1'b1; cmd_load = load; cmd_len = len; r_start = cyc;
    @(negedge aclk);
    start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (a_ready || b_ready) r_ab_ready = 1'b1;
      if (pe_valid) begin
        if (outstanding) r_overlap = 1'b1;
        if (r_issues > 0 && (cyc - r_last_issue - 1) < r_min_gap)
          r_min_gap = cyc - r_last_issue - 1;
        if (r_issues == 0) r_first_issue = cyc;
        r_last_issue = cyc;
        r_issues++;
        outstanding = 1'b1;
      end
      if (pe_dvalid && outstanding) begin
        outstanding = 1'b0;
        r_last_dv = cyc;
      end
      if (a_cnt == stall_after && stall_left > 0) begin
        a_valid = 1'b0;
        stall_left--;
        if (pe_valid && seen_rd) r_stall_pv = 1'b1;
        if (a_ready) begin
          r_stall_rd++;
          seen_rd = 1'b1;
        end
      end else begin
        a_valid = (a_cnt < n);
        a_data  = aw;
        if (a_valid && a_ready) a_cnt++;
      end
      b_valid = load && (b_cnt < n);
      b_data  = bw;
      if (b_valid && b_ready) b_cnt++;
      if (res_valid) begin
        r_resv = cyc; r_data = res_data; r_err = err;
        res_ready = 1'b1;
        @(negedge aclk);
        res_ready = 1'b0;
        r_done = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    tests++;
    if (pe_aresetn !== 1'b0) begin
      fails++; $display("FAIL reset_pe_aresetn: got %b expected 0", pe_aresetn);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    tests++;
    if ({busy, err, res_valid, a_ready, b_ready, pe_we, pe_valid} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, err, res_valid, a_ready, b_ready, pe_we, pe_valid});
    end
    tests++;
    if ({pe_addr, pe_din, pe_ain, res_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr %h din %h ain %h res %h expected all 0",
               pe_addr, pe_din, pe_ain, res_data);
    end
    tests++;
    if (pe_aresetn !== 1'b1) begin
      fails++; $display("FAIL reset_release_pe_aresetn: got %b expected 1", pe_aresetn);
    end
  endtask

  task automatic test_load_compute();
    run_cmd(1'b1, 7'd4, ONE, TWO, -1, 0);
    tests++;
    if (r_done !== 1'b1 || r_data !== 32'h4100_0000) begin
      fails++; $display("FAIL load_result: done %b data %h expected 1 41000000", r_done, r_data);
    end
    tests++;
    if (r_issues !== 4 || r_overlap !== 1'b0) begin
      fails++; $display("FAIL load_issues: count %0d overlap %b expected 4 0", r_issues, r_overlap);
    end
    tests++;
    if (r_min_gap < 6) begin
      fails++; $display("FAIL load_issue_gap: got %0d expected >= 6", r_min_gap);
    end
    tests++;
    if (r_resv !== r_last_dv + 1) begin
      fails++; $display("FAIL load_dv_to_res: got %0d expected %0d", r_resv, r_last_dv + 1);
    end
  endtask

  task automatic test_reuse();
    run_cmd(1'b0, 7'd4, 32'd0, ONE, -1, 0);
    tests++;
    if (r_done !== 1'b1 || r_data !== 32'h4080_0000) begin
      fails++; $display("FAIL reuse_result: done %b data %h expected 1 40800000", r_done, r_data);
    end
    tests++;
    if (r_first_issue - r_start !== 4) begin
      fails++; $display("FAIL reuse_start_latency: got %0d expected 4", r_first_issue - r_start);
    end
  endtask

  task automatic test_stall();
    run_cmd(1'b0, 7'd4, 32'd0, TWO, 2, 10);
    tests++;
    if (r_done !== 1'b1 || r_data !== 32'h4100_0000) begin
      fails++; $display("FAIL stall_result: done %b data %h expected 1 41000000", r_done, r_data);
    end
    tests++;
    if (r_stall_rd !== 4 || r_stall_pv !== 1'b0) begin
      fails++;
      $display("FAIL stall_hold: rd cycles %0d pe_valid %b expected 4 0", r_stall_rd, r_stall_pv);
    end
  endtask

  task automatic test_len_zero();
    run_cmd(1'b1, 7'd0, ONE, ONE, -1, 0);
    tests++;
    if (r_done !== 1'b1 || r_data !== 32'd0) begin
      fails++; $display("FAIL len0_result: done %b data %h expected 1 0", r_done, r_data);
    end
    tests++;
    if (r_resv - r_start < 1 || r_resv - r_start > 4) begin
      fails++; $display("FAIL len0_latency: got %0d expected 1..4", r_resv - r_start);
    end
    tests++;
    if (r_ab_ready !== 1'b0 || r_issues !== 0) begin
      fails++; $display("FAIL len0_streams: ready %b issues %0d expected 0 0", r_ab_ready, r_issues);
    end
  endtask

  task automatic test_timeout();
    suppress = 1'b1;
    run_cmd(1'b0, 7'd1, 32'd0, ONE, -1, 0);
    suppress = 1'b0;
    tests++;
    if (r_done !== 1'b1 || r_err !== 1'b1 || r_data !== 32'd0) begin
      fails++;
      $display("FAIL timeout_err: done %b err %b data %h expected 1 1 0", r_done, r_err, r_data);
    end
    tests++;
    if (r_resv - r_first_issue !== 17) begin
      fails++; $display("FAIL timeout_latency: got %0d expected 17", r_resv - r_first_issue);
    end
    tests++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL timeout_sticky: got %b expected 1", err);
    end
    run_cmd(1'b0, 7'd0, 32'd0, ONE, -1, 0);
    tests++;
    if (r_done !== 1'b1 || r_err !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL timeout_clear: done %b err %b/%b expected 1 0/0", r_done, r_err, err);
    end
  endtask

  task automatic test_reset_in_wait();
    bit found = 1'b0;
    bit saw_res = 1'b0;
    bit saw_busy = 1'b0;
    @(negedge aclk);
    start = 1'b1; cmd_load = 1'b0; cmd_len = 7'd4;
    @(negedge aclk);
    start = 1'b0; a_valid = 1'b1; a_data = ONE;
    for (int k = 0; k < 20; k++) begin
      if (pe_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    a_valid = 1'b0;
    tests++;
    if (!found) begin
      fails++; $display("FAIL rstwait_issue: got no pe_valid within 20 cycles, expected one");
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    tests++;
    if (pe_aresetn !== 1'b0) begin
      fails++; $display("FAIL rstwait_pe_aresetn: got %b expected 0", pe_aresetn);
    end
    @(negedge aclk);
    tests++;
    if ({busy, err, res_valid, a_ready, b_ready, pe_we, pe_valid} !== 7'b0 ||
        {pe_addr, pe_din, pe_ain, res_data} !== '0) begin
      fails++;
      $display("FAIL rstwait_outputs: flags %b ain %h addr %h res %h expected all 0",
               {busy, err, res_valid, a_ready, b_ready, pe_we, pe_valid}, pe_ain, pe_addr, res_data);
    end
    aresetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (res_valid) saw_res = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    tests++;
    if (saw_res || saw_busy) begin
      fails++; $display("FAIL rstwait_quiet: res_valid %b busy %b expected 0 0", saw_res, saw_busy);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_compute();
    test_reuse();
    test_stall();
    test_len_zero();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
